// File: rtl/stage_fd.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer.
// A fetch that the synchronous instruction memory returns while the stage is
// stalled is parked in the skid buffer and presented on the first release cycle
// (the drain cycle), so no fetch is lost or duplicated. A flush turns the stage
// into a bubble and empties the skid buffer.
//
// Handshake: inst_valid_fi is a valid-only strobe from the fetch side; there is
// no ready. Back-pressure is pc_hold_o, which is combinational
// (pipeline_stall_i | skid_full). While it is high the PC must not advance. A
// fetch that arrives while the skid is already full, or during a drain cycle,
// cannot be stored. It is dropped and flagged on the sticky skid_ovf_o.
module stage_fd #(
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pipeline_flush_i,
  input  logic             pipeline_stall_i,
  input  logic [31:0]      pc_fi,
  input  logic [31:0]      inst_fi,
  input  logic             inst_valid_fi,
  output logic [31:0]      inst_do,
  output logic [31:0]      pc_do,
  output logic             valid_do,
  output logic [4:0]       rs1_do,
  output logic [4:0]       rs2_do,
  output logic             pc_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             skid_ovf_o,
  output logic             state_o
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [4:0]       NOP_RS1 = NOP_INST[19:15];
  localparam logic [4:0]       NOP_RS2 = NOP_INST[24:20];
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic        skid_full;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;

  // Debug view of the FSM: 1 while the stage is in STALL.
  assign state_o = (state == STALL);

  // The PC must wait while stalled and also for the drain cycle of a full skid.
  assign pc_hold_o = pipeline_stall_i | skid_full;

  // Pipeline register, skid buffer and FSM. Priority: flush > drain > stall > load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inst_do    <= NOP_INST;
      pc_do      <= '0;
      valid_do   <= 1'b0;
      rs1_do     <= NOP_RS1;
      rs2_do     <= NOP_RS2;
      skid_full  <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      skid_ovf_o <= 1'b0;
      state      <= RUN;
    end else if (pipeline_flush_i) begin
      inst_do   <= NOP_INST;
      pc_do     <= '0;
      valid_do  <= 1'b0;
      rs1_do    <= NOP_RS1;
      rs2_do    <= NOP_RS2;
      skid_full <= 1'b0;
      skid_pc   <= '0;
      skid_inst <= '0;
      state     <= RUN;
    end else if (state == STALL && !pipeline_stall_i && skid_full) begin
      // Drain cycle: present the parked fetch. A new fetch has nowhere to go.
      inst_do   <= skid_inst;
      pc_do     <= skid_pc;
      valid_do  <= 1'b1;
      rs1_do    <= skid_inst[19:15];
      rs2_do    <= skid_inst[24:20];
      skid_full <= 1'b0;
      state     <= RUN;
      if (inst_valid_fi) begin
        skid_ovf_o <= 1'b1;
      end
    end else if (pipeline_stall_i) begin
      // Outputs hold. The first fetch seen during the stall is parked.
      state <= STALL;
      if (inst_valid_fi) begin
        if (!skid_full) begin
          skid_full <= 1'b1;
          skid_pc   <= pc_fi;
          skid_inst <= inst_fi;
        end else begin
          skid_ovf_o <= 1'b1;
        end
      end
    end else begin
      state <= RUN;
      if (inst_valid_fi) begin
        inst_do  <= inst_fi;
        pc_do    <= pc_fi;
        valid_do <= 1'b1;
        rs1_do   <= inst_fi[19:15];
        rs2_do   <= inst_fi[24:20];
      end else begin
        inst_do  <= NOP_INST;
        pc_do    <= '0;
        valid_do <= 1'b0;
        rs1_do   <= NOP_RS1;
        rs2_do   <= NOP_RS2;
      end
    end
  end

  // Saturating count of stalled cycles. It keeps counting through a flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (pipeline_stall_i && stall_cnt_o != CNT_MAX) begin
      stall_cnt_o <= stall_cnt_o + CNT_ONE;
    end
  end

endmodule

// File: doc/stage_fd.md
Name: stage_FD

Overview:
Fetch-to-decode pipeline register. It sits between the instruction-memory/PC block and the decoder, which feeds stage_DE. It holds its contents on a stall and converts a flush into a bubble. A one-entry skid buffer captures an instruction that the synchronous instruction memory returns while the stage is stalled, so no fetch is lost or duplicated. It also drives the PC hold request and a saturating stall-cycle counter.

Parameters:
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) driven on reset and flush.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-low (asserted = `RESET_ENABLE = 0).
pipeline_flush_i  in  1  flush request (`PLFLUSH_ENABLE); kills the current FD contents and the skid buffer.
pipeline_stall_i  in  1  hold request from the hazard logic; active high.
pc_fi  in  32  PC of the instruction on inst_fi.
inst_fi  in  32  instruction word from instruction memory, one cycle after its address.
inst_valid_fi  in  1  inst_fi/pc_fi carry a new fetch this cycle.
inst_do  out  32  instruction to the decoder.
pc_do  out  32  PC to the decoder.
valid_do  out  1  inst_do is a real instruction, not a bubble.
rs1_do  out  5  registered inst[19:15] of the next inst_do, for register-file read.
rs2_do  out  5  registered inst[24:20] of the next inst_do.
pc_hold_o  out  1  combinational: pipeline_stall_i | skid_full; the PC must not advance.
stall_cnt_o  out  CNT_W  saturating count of stalled cycles.
skid_ovf_o  out  1  sticky error: a fetch arrived while the skid buffer was full, or during a drain cycle.

Behaviour:
- Reset (async, rst_i low):
  - inst_do=NOP_INST, pc_do=0, valid_do=0, rs1_do=0, rs2_do=0.
  - skid buffer empty (skid_full=0, contents 0).
  - state=RUN, stall_cnt_o=0, skid_ovf_o=0.
  - Reset mid-stall discards the skid contents.
- Priority each clock edge: reset > flush > drain > stall > normal load.
- Flush (any state):
  - Outputs take the reset values (bubble).
  - Skid cleared; state goes to RUN.
  - inst_valid_fi in the same cycle is discarded.
  - stall_cnt_o still counts if pipeline_stall_i=1.
- States: RUN, STALL.
- RUN, stall=0:
  - If inst_valid_fi=1, load inst_do/pc_do/rs1_do/rs2_do from the inputs and set valid_do=1.
  - Else load a bubble (NOP_INST, pc 0, valid 0). Latency: 1 cycle.
- RUN, stall=1:
  - Outputs hold; go to STALL.
  - If inst_valid_fi=1, capture {pc_fi, inst_fi} into the skid and set skid_full=1.
- STALL, stall=1:
  - Outputs hold.
  - If inst_valid_fi=1 and skid empty, capture into the skid.
  - If inst_valid_fi=1 and skid full, keep the old skid entry and set skid_ovf_o.
- STALL, stall=0 (release):
  - If skid_full: drain cycle. Outputs load from the skid with valid_do=1, and skid_full clears.
    - pc_hold_o stays 1 during this cycle because skid_full=1.
    - An inst_valid_fi arriving in this cycle is dropped and sets skid_ovf_o.
  - If skid empty: behave as RUN with stall=0.
  - Next state is RUN in both cases.
- Counter:
  - stall_cnt_o increments on every edge where pipeline_stall_i=1.
  - It saturates at all-ones; it never wraps.
- skid_ovf_o clears only on reset.
- rs1_do/rs2_do always equal inst_do[19:15]/[24:20] of the registered value, including bubbles (0 for NOP_INST).

Test Plan:
- Normal flow: pc_fi=0x0,0x4,0x8 with inst_valid_fi=1 over three cycles -> pc_do/inst_do follow one cycle later with valid_do=1; pc_hold_o=0 throughout.
- Stall with late fetch: stall for 3 cycles; inst 0x00500093 @0x10 arrives in the first stall cycle -> outputs hold the previous instruction. On release: drain cycle presents 0x00500093/0x10, pc_hold_o=1 for that cycle, and rs1_do=0, rs2_do=5.
- Flush during stall with skid full -> next cycle inst_do=0x00000013, valid_do=0, pc_do=0. The skid is empty and the following fetch loads normally.
- Double fetch while skid full -> skid keeps the first entry and skid_ovf_o=1, staying sticky until reset.
- Counter saturation (CNT_W=4): hold stall for 20 cycles -> stall_cnt_o=15.
- Async reset asserted mid-stall, between clock edges -> all outputs return to reset values immediately, before the next edge.
